// File: rtl/alu_legv8_pkg.sv
// Shared definitions for the multi-cycle LEGv8 execute unit: op codes,
// FSM states and status-bit positions.
package alu_legv8_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_LSL = 3'b100;
    localparam logic [2:0] OP_LSR = 3'b101;
    localparam logic [2:0] OP_ASR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_C = 2;
    localparam int ST_V = 3;

endpackage

// File: rtl/mul_iter_legv8.sv
// Radix-2 shift-add multiplier, one partial product per cycle, WIDTH iterations.
// done is high during the last iteration and p then carries the final product.
module mul_iter_legv8 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] p
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign done       = r_busy && (r_cnt == CNT_LAST);
    assign p          = w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (done) r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc_legv8.sv
// Multi-cycle LEGv8 execute unit: single-cycle logic/add/shift ops, iterative
// MUL, valid/ready operand and result handshakes, and the NZCV flag register.
module alu_mc_legv8
    import alu_legv8_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       fs,
    input  logic             c0,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic [3:0]       status,
    output logic [3:0]       flags
);
    state_t           r_state;
    logic [WIDTH-1:0] r_f;
    logic [3:0]       r_status;
    logic [3:0]       r_flags;
    logic             r_set_flags;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_op;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_alu_f;
    logic [3:0]       w_alu_status;
    logic [3:0]       w_mul_status;
    logic [WIDTH-1:0] w_mul_p;
    logic             w_mul_done;
    logic             w_accept;

    assign w_a     = fs[0] ? ~a : a;
    assign w_b     = fs[1] ? ~b : b;
    assign w_op    = fs[4:2];
    assign w_shamt = b[SHW-1:0];
    assign w_sum   = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, c0};

    // Shifts deliberately use the raw a operand, not the inverted one.
    always_comb begin
        w_alu_f = '0;
        case (w_op)
            OP_AND:  w_alu_f = w_a & w_b;
            OP_OR:   w_alu_f = w_a | w_b;
            OP_ADD:  w_alu_f = w_sum[WIDTH-1:0];
            OP_XOR:  w_alu_f = w_a ^ w_b;
            OP_LSL:  w_alu_f = a << w_shamt;
            OP_LSR:  w_alu_f = a >> w_shamt;
            OP_ASR:  w_alu_f = $signed(a) >>> w_shamt;
            default: w_alu_f = '0;
        endcase
    end

    always_comb begin
        w_alu_status       = '0;
        w_alu_status[ST_Z] = (w_alu_f == '0);
        w_alu_status[ST_N] = w_alu_f[WIDTH-1];
        if (w_op == OP_ADD) begin
            w_alu_status[ST_C] = w_sum[WIDTH];
            w_alu_status[ST_V] = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                                 (w_sum[WIDTH-1] != w_a[WIDTH-1]);
        end
    end

    always_comb begin
        w_mul_status       = '0;
        w_mul_status[ST_Z] = (w_mul_p == '0);
        w_mul_status[ST_N] = w_mul_p[WIDTH-1];
    end

    assign in_ready  = !clear && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign f         = r_f;
    assign status    = r_status;
    assign flags     = r_flags;

    mul_iter_legv8 #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_accept && (w_op == OP_MUL)),
        .a     (w_a),
        .b     (w_b),
        .done  (w_mul_done),
        .p     (w_mul_p)
    );

    // A stale multiplier completion after clear is ignored: done only counts in BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_f         <= '0;
            r_status    <= '0;
            r_flags     <= '0;
            r_set_flags <= 1'b0;
        end else if (clear) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_set_flags <= set_flags;
                        if (w_op == OP_MUL) begin
                            r_state <= BUSY;
                        end else begin
                            r_f      <= w_alu_f;
                            r_status <= w_alu_status;
                            if (set_flags) r_flags <= w_alu_status;
                            r_state  <= DONE;
                        end
                    end else if (r_state == DONE && out_ready) begin
                        r_state <= IDLE;
                    end
                end
                BUSY: begin
                    if (w_mul_done) begin
                        r_f      <= w_mul_p;
                        r_status <= w_mul_status;
                        if (r_set_flags) r_flags <= w_mul_status;
                        r_state  <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc_legv8.sv
// Scoreboarded bench for alu_mc_legv8 at WIDTH=64 and WIDTH=8 with directed,
// hand-computed vectors.
module tb_alu_mc_legv8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        clr64 = 0, iv64 = 0, or64 = 1, c064 = 0, sf64 = 0;
    logic        ir64, ov64;
    logic [63:0] a64 = 0, b64 = 0, f64;
    logic [4:0]  fs64 = 0;
    logic [3:0]  st64, fl64;

    logic        clr8 = 0, iv8 = 0, or8 = 1, c08 = 0, sf8 = 0;
    logic        ir8, ov8;
    logic [7:0]  a8 = 0, b8 = 0, f8;
    logic [4:0]  fs8 = 0;
    logic [3:0]  st8, fl8;

    alu_mc_legv8 #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .clear(clr64), .in_valid(iv64), .in_ready(ir64),
        .a(a64), .b(b64), .fs(fs64), .c0(c064), .set_flags(sf64),
        .out_valid(ov64), .out_ready(or64), .f(f64), .status(st64), .flags(fl64)
    );

    alu_mc_legv8 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clr8), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .fs(fs8), .c0(c08), .set_flags(sf8),
        .out_valid(ov8), .out_ready(or8), .f(f8), .status(st8), .flags(fl8)
    );

    typedef struct packed {
        logic [63:0] f;
        logic [3:0]  st;
        logic [3:0]  fl;
    } exp_t;

    exp_t       q64[$];
    exp_t       q8[$];
    logic [3:0] m64 = 4'd0;
    logic [3:0] m8  = 4'd0;
    int         n_chk  = 0;
    int         n_pass = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic push64(input logic [63:0] ef, input logic [3:0] est, input logic sf);
        exp_t e;
        if (sf) m64 = est;
        e.f = ef; e.st = est; e.fl = m64;
        q64.push_back(e);
    endtask

    task automatic push8(input logic [7:0] ef, input logic [3:0] est, input logic sf);
        exp_t e;
        if (sf) m8 = est;
        e.f = {56'd0, ef}; e.st = est; e.fl = m8;
        q8.push_back(e);
    endtask

    // Monitors: every completed result transfer is checked against the queue head.
    always @(negedge clk) begin
        if (rst_n && ov64 && or64) begin
            if (q64.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected64: result f=%h with no pending bundle", f64);
            end else begin
                exp_t e;
                e = q64.pop_front();
                check("f64", f64, e.f);
                check("status64", 64'(st64), 64'(e.st));
                check("flags64", 64'(fl64), 64'(e.fl));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov8 && or8) begin
            if (q8.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected8: result f=%h with no pending bundle", f8);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("f8", 64'(f8), e.f);
                check("status8", 64'(st8), 64'(e.st));
                check("flags8", 64'(fl8), 64'(e.fl));
            end
        end
    end

    task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic [4:0] fs,
                          input logic c0, input logic sf, input logic [63:0] ef,
                          input logic [3:0] est, input bit keep, output int waited);
        a64 = a; b64 = b; fs64 = fs; c064 = c0; sf64 = sf; iv64 = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!ir64 && waited < 200) begin waited++; @(negedge clk); end
        if (!ir64) begin
            n_chk++;
            $display("FAIL accept64_timeout: in_ready still 0 after %0d cycles", waited);
        end else if (keep) push64(ef, est, sf);
        @(posedge clk); #1;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [4:0] fs,
                         input logic c0, input logic sf, input logic [7:0] ef,
                         input logic [3:0] est);
        int waited;
        a8 = a; b8 = b; fs8 = fs; c08 = c0; sf8 = sf; iv8 = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!ir8 && waited < 200) begin waited++; @(negedge clk); end
        if (!ir8) begin
            n_chk++;
            $display("FAIL accept8_timeout: in_ready still 0 after %0d cycles", waited);
        end else push8(ef, est, sf);
        @(posedge clk); #1;
    endtask

    // Called just after the accept edge; the accept edge itself counts as cycle 1.
    task automatic wait_valid64(output int lat);
        lat = 1;
        while (!ov64 && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic wait_valid8(output int lat);
        lat = 1;
        while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((q64.size() != 0 || q8.size() != 0) && n < 300) begin @(posedge clk); n++; end
        @(posedge clk); #1;
        check(nm, 64'(q64.size() + q8.size()), 64'd0);
    endtask

    logic [63:0] sa[4]  = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd10};
    logic [63:0] sb[4]  = '{64'd2, 64'd1, 64'h8000_0000_0000_0000, 64'd3};
    logic [4:0]  sfs[4] = '{5'b01000, 5'b01000, 5'b01000, 5'b01010};
    logic        sc0[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        ssf[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] sef[4] = '{64'd3, 64'd0, 64'd0, 64'd7};
    logic [3:0]  sst[4] = '{4'b0000, 4'b0101, 4'b1101, 4'b0100};

    initial begin
        int w, lat, stalls;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(ov64), 64'd0);
        check("rst_f", f64, 64'd0);
        check("rst_status", 64'(st64), 64'd0);
        check("rst_flags64", 64'(fl64), 64'd0);
        check("rst_flags8", 64'(fl8), 64'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        check("rst_in_ready", 64'(ir64), 64'd1);
        @(posedge clk); #1;

        // Signed overflow with flag commit, one-cycle latency
        send64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 0, 1, 64'h8000_0000_0000_0000, 4'b1010, 1, w);
        iv64 = 0;
        wait_valid64(lat);
        check("lat_add64", 64'(lat), 64'd1);
        send64(64'd5, 64'd5, 5'b01010, 1, 0, 64'd0, 4'b0101, 1, w);
        send64(64'hFF00, 64'h0FF0, 5'b00011, 0, 0, 64'hFFFF_FFFF_FFFF_000F, 4'b0010, 1, w);
        send64(64'd1, 64'd67, 5'b10000, 0, 0, 64'd8, 4'b0000, 1, w);
        send64(64'h8000_0000_0000_0000, 64'd63, 5'b10100, 0, 0, 64'd1, 4'b0000, 1, w);
        send64(64'h1234, 64'h1234, 5'b01100, 0, 0, 64'd0, 4'b0001, 1, w);
        iv64 = 0;
        drain("drain_logic");

        send64(64'd3, 64'd5, 5'b11100, 0, 0, 64'd15, 4'b0000, 1, w);
        iv64 = 0;
        wait_valid64(lat);
        check("lat_mul64", 64'(lat), 64'd65);
        send64(64'd2, 64'd0, 5'b11110, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010, 1, w);
        iv64 = 0;
        drain("drain_mul64");

        // ASR then backpressure with a bundle waiting
        or64 = 0;
        send64(64'h8000_0000_0000_0000, 64'd4, 5'b11000, 0, 1, 64'hF800_0000_0000_0000, 4'b0010, 1, w);
        a64 = 64'hF0; b64 = 64'h0F; fs64 = 5'b00100; c064 = 0; sf64 = 0; iv64 = 1;
        repeat (3) begin
            @(negedge clk);
            check("bp_f_stable", f64, 64'hF800_0000_0000_0000);
            check("bp_in_ready", 64'(ir64), 64'd0);
            check("bp_out_valid", 64'(ov64), 64'd1);
        end
        @(posedge clk); #1;
        or64 = 1;
        @(negedge clk);
        check("bp_accept_same_cycle", 64'(ir64), 64'd1);
        if (ir64) push64(64'hFF, 4'b0000, 0);
        @(posedge clk); #1;
        iv64 = 0;
        drain("drain_bp");

        // Abort a MUL with a competing bundle; neither may surface
        send64(64'd3, 64'd5, 5'b11100, 0, 1, 64'd15, 4'b0000, 0, w);
        iv64 = 0;
        repeat (4) @(posedge clk);
        #1;
        clr64 = 1; a64 = 64'd7; b64 = 64'd9; fs64 = 5'b01000; sf64 = 1; iv64 = 1;
        @(negedge clk);
        check("clr_in_ready", 64'(ir64), 64'd0);
        @(posedge clk); #1;
        clr64 = 0; iv64 = 0;
        @(negedge clk);
        check("clr_out_valid", 64'(ov64), 64'd0);
        check("clr_idle_ready", 64'(ir64), 64'd1);
        repeat (80) @(posedge clk);
        #1;

        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            send64(sa[i], sb[i], sfs[i], sc0[i], ssf[i], sef[i], sst[i], 1, w);
            stalls += w;
        end
        iv64 = 0;
        check("stream_stalls", 64'(stalls), 64'd0);
        drain("drain_stream");

        // WIDTH=8 block
        send8(8'h7F, 8'h01, 5'b01000, 0, 1, 8'h80, 4'b1010);
        send8(8'h0F, 8'h11, 5'b11100, 0, 1, 8'hFF, 4'b0010);
        iv8 = 0;
        wait_valid8(lat);
        check("lat_mul8", 64'(lat), 64'd9);
        send8(8'hFF, 8'h01, 5'b01000, 0, 0, 8'h00, 4'b0101);
        send8(8'hFE, 8'h80, 5'b11101, 0, 0, 8'h80, 4'b0010);
        iv8 = 0;
        drain("drain_w8");

        // Asynchronous reset in the middle of a MUL
        send64(64'd3, 64'd5, 5'b11100, 0, 1, 64'd15, 4'b0000, 0, w);
        iv64 = 0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("amid_out_valid", 64'(ov64), 64'd0);
        check("amid_flags64", 64'(fl64), 64'd0);
        check("amid_flags8", 64'(fl8), 64'd0);
        check("amid_f", f64, 64'd0);
        m64 = 4'd0; m8 = 4'd0;
        @(negedge clk); rst_n = 1'b1; #1;
        check("amid_in_ready", 64'(ir64), 64'd1);
        @(posedge clk); #1;
        send64(64'd1, 64'd2, 5'b01000, 0, 1, 64'd3, 4'b0000, 1, w);
        iv64 = 0;
        drain("drain_post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
